branch_resolve_unit: RTL and testbench

Parametrised, pipelined branch resolution stage for the RV32I pipeline. Evaluates the six conditional-branch comparisons on WIDTH-bit operands and checks the outcome against the fetch-stage prediction. Produces the redirect PC and a mispredict flag through a valid/ready pipeline of STAGES registers. Keeps saturating branch and mispredict performance counters. It sits in EX, between operand forwarding and the PC-redirect logic; illegal funct3 is flagged, not fatal.

---
 rtl/brres_pkg.sv | 29 ++
 rtl/rv32i_types.sv | 18 +
 rtl/branch_cmp_core.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 189 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/brres_pkg.sv
// ---------------------------------------------------------------------------
// brres_pkg
// Types and constants for the branch resolution stage.
//   F3_ILLEGAL_A/B   : the two funct3 codes that are not branches.
//   brres_payload_t  : everything that travels down the pipeline for a beat.
//                      redirect_pc is sized for the widest supported datapath
//                      (BRRES_PC_MAX_W); narrower instances keep the upper
//                      bits at zero and they optimise away.
//   is_illegal_f3()  : true for the non-branch funct3 codes.
// ---------------------------------------------------------------------------
package brres_pkg;

  localparam int unsigned BRRES_PC_MAX_W = 64;

  localparam logic [2:0] F3_ILLEGAL_A = 3'b010;
  localparam logic [2:0] F3_ILLEGAL_B = 3'b011;

  typedef struct packed {
    logic                      taken;
    logic                      mispredict;
    logic                      illegal_op;
    logic [BRRES_PC_MAX_W-1:0] redirect_pc;
  } brres_payload_t;

  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3 == F3_ILLEGAL_A) || (f3 == F3_ILLEGAL_B);
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared RV32I encodings used across the pipeline.
//   branch_funct3_t : funct3 field of conditional-branch instructions.
//                     3'b010 and 3'b011 have no branch meaning.
// ---------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

endpackage

// File: rtl/branch_cmp_core.sv
// ---------------------------------------------------------------------------
// branch_cmp_core
// Purely combinational branch condition evaluation on WIDTH-bit operands.
// Ports:
//   op_i      : branch funct3
//   a_i, b_i  : rs1 / rs2 values
//   taken_o   : condition holds (always 0 for a non-branch funct3)
//   illegal_o : funct3 is not a branch encoding
// ---------------------------------------------------------------------------
module branch_cmp_core
  import rv32i_types::*;
  import brres_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             taken_o,
  output logic             illegal_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a_i == b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));
  assign lt_u = (a_i < b_i);

  always_comb begin
    illegal_o = is_illegal_f3(op_i);
    taken_o   = 1'b0;
    case (op_i)
      BR_BEQ:  taken_o = eq;
      BR_BNE:  taken_o = !eq;
      BR_BLT:  taken_o = lt_s;
      BR_BGE:  taken_o = !lt_s;
      BR_BLTU: taken_o = lt_u;
      BR_BGEU: taken_o = !lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// EX-stage branch resolution: evaluates the branch condition, compares it with
// the fetch prediction and delivers the redirect PC through STAGES valid/ready
// register slots. Keeps saturating retired-branch and mispredict counters.
//
// Handshake: a beat moves across an interface in a cycle where valid and
// ready are both 1 at the clock edge; a producer holds its payload stable
// while valid=1 and ready=0.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready is combinational)
//   op, a, b, pc, target, pred_taken : branch beat contents
//   flush               : drop every in-flight beat at the next edge
//   out_valid/out_ready : output handshake
//   taken, mispredict, illegal_op, redirect_pc : resolved result
//   branch_cnt, mispred_cnt : saturating counters, cleared by cnt_clr
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import brres_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STAGES    = 1,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     pc,
  input  logic [WIDTH-1:0]     target,
  input  logic                 pred_taken,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 taken,
  output logic                 mispredict,
  output logic [WIDTH-1:0]     redirect_pc,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt,
  input  logic                 cnt_clr
);

  localparam int LAST = int'(STAGES) - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // -------------------------------------------------------------------------
  // Resolve before stage 0 so every slot carries a finished result.
  // -------------------------------------------------------------------------
  logic             cmp_taken;
  logic             cmp_illegal;
  logic [WIDTH-1:0] pc_plus4;
  brres_payload_t   in_payload;

  branch_cmp_core #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );

  // Wraps modulo 2^WIDTH; the carry out is intentionally dropped.
  assign pc_plus4 = pc + WIDTH'(4);

  always_comb begin
    in_payload                         = '0;
    in_payload.taken                   = cmp_taken;
    in_payload.illegal_op              = cmp_illegal;
    // A non-branch funct3 never counts as a mispredict.
    in_payload.mispredict              = !cmp_illegal && (cmp_taken != pred_taken);
    in_payload.redirect_pc[WIDTH-1:0]  = cmp_taken ? target : pc_plus4;
  end

  // -------------------------------------------------------------------------
  // Pipeline slots
  // -------------------------------------------------------------------------
  logic [STAGES-1:0] slot_valid;
  logic [STAGES-1:0] slot_adv;
  brres_payload_t    slot_data [STAGES];
  logic              accept;

  // Advance chain runs from the output back to slot 0 so a stalled output
  // only stalls the slots behind it that are actually occupied.
  always_comb begin
    slot_adv       = '0;
    slot_adv[LAST] = slot_valid[LAST] && out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      slot_adv[k] = slot_valid[k] && (!slot_valid[k+1] || slot_adv[k+1]);
    end
  end

  // During flush everything is about to be dropped, so accepting is harmless.
  assign in_ready = !rst && (flush || !slot_valid[0] || slot_adv[0]);
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic           valid_q;
    brres_payload_t data_q;
    logic           fill;
    brres_payload_t fill_data;

    if (k == 0) begin : g_head
      assign fill      = accept;
      assign fill_data = in_payload;
    end else begin : g_body
      assign fill      = slot_adv[k-1];
      assign fill_data = slot_data[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= fill || (valid_q && !slot_adv[k]);
        if (fill) begin
          data_q <= fill_data;
        end
      end
    end

    assign slot_valid[k] = valid_q;
    assign slot_data[k]  = data_q;
  end

  assign out_valid   = slot_valid[LAST];
  assign taken       = slot_data[LAST].taken;
  assign mispredict  = slot_data[LAST].mispredict;
  assign illegal_op  = slot_data[LAST].illegal_op;
  assign redirect_pc = slot_data[LAST].redirect_pc[WIDTH-1:0];

  if (WIDTH < BRRES_PC_MAX_W) begin : g_pc_hi
    // Upper payload bits stay zero for narrow instances.
    logic unused_pc_hi;
    assign unused_pc_hi = ^slot_data[LAST].redirect_pc[BRRES_PC_MAX_W-1:WIDTH];
  end

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  logic                 retire;
  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q;
  logic [CNT_WIDTH-1:0] mispred_cnt_d;

  // A beat retiring under flush is discarded, so it is not counted.
  assign retire = out_valid && out_ready && !flush;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (cnt_clr) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (retire) begin
      if (!illegal_op && (branch_cnt_q != CNT_MAX)) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
      if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int W = 32;

  // -------------------------------------------------------------------------
  // Clock / reset / shared stimulus
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         flush;
  logic         cnt_clr;
  logic         out_ready;
  logic         pred_taken;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] pc;
  logic [W-1:0] target;

  logic in_valid_1, in_valid_3, in_valid_4;

  logic         in_ready_1, out_valid_1, taken_1, mispredict_1, illegal_1;
  logic [W-1:0] redirect_1, bcnt_1, mcnt_1;
  logic         in_ready_3, out_valid_3, taken_3, mispredict_3, illegal_3;
  logic [W-1:0] redirect_3, bcnt_3, mcnt_3;
  logic         in_ready_4, out_valid_4, taken_4, mispredict_4, illegal_4;
  logic [W-1:0] redirect_4;
  logic [3:0]   bcnt_4, mcnt_4;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(.WIDTH(W), .STAGES(1), .CNT_WIDTH(32)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .op(op), .a(a), .b(b), .pc(pc), .target(target), .pred_taken(pred_taken),
    .flush(flush), .out_valid(out_valid_1), .out_ready(out_ready),
    .taken(taken_1), .mispredict(mispredict_1), .redirect_pc(redirect_1),
    .illegal_op(illegal_1), .branch_cnt(bcnt_1), .mispred_cnt(mcnt_1),
    .cnt_clr(cnt_clr)
  );

  branch_resolve_unit #(.WIDTH(W), .STAGES(3), .CNT_WIDTH(32)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_3), .in_ready(in_ready_3),
    .op(op), .a(a), .b(b), .pc(pc), .target(target), .pred_taken(pred_taken),
    .flush(flush), .out_valid(out_valid_3), .out_ready(out_ready),
    .taken(taken_3), .mispredict(mispredict_3), .redirect_pc(redirect_3),
    .illegal_op(illegal_3), .branch_cnt(bcnt_3), .mispred_cnt(mcnt_3),
    .cnt_clr(cnt_clr)
  );

  branch_resolve_unit #(.WIDTH(W), .STAGES(1), .CNT_WIDTH(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .op(op), .a(a), .b(b), .pc(pc), .target(target), .pred_taken(pred_taken),
    .flush(flush), .out_valid(out_valid_4), .out_ready(out_ready),
    .taken(taken_4), .mispredict(mispredict_4), .redirect_pc(redirect_4),
    .illegal_op(illegal_4), .branch_cnt(bcnt_4), .mispred_cnt(mcnt_4),
    .cnt_clr(cnt_clr)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (out_valid_1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid_1); end
    n_checks++; if (in_ready_1 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 0", in_ready_1); end
    n_checks++; if ({taken_1, mispredict_1, illegal_1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %03b exp 000", {taken_1, mispredict_1, illegal_1}); end
    n_checks++; if (redirect_1 !== 32'h0) begin n_fail++; $display("FAIL reset_redirect got %08h exp 00000000", redirect_1); end
    n_checks++; if (bcnt_1 !== 32'h0 || mcnt_1 !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", bcnt_1, mcnt_1); end
    n_checks++; if (out_valid_3 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_s3 got %0b exp 0", out_valid_3); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready_4 !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %0b exp 1", in_ready_4); end
    step();
  endtask

  task automatic test_blt();
    op = 3'b100; a = 32'hFFFF_FFFF; b = 32'h1; pc = 32'h200; target = 32'h1000;
    pred_taken = 1'b0; out_ready = 1'b0; in_valid_1 = 1'b1;
    #1;
    n_checks++; if (in_ready_1 !== 1'b1) begin n_fail++; $display("FAIL blt_in_ready_empty got %0b exp 1", in_ready_1); end
    step();
    in_valid_1 = 1'b0;
    #1;
    n_checks++; if (out_valid_1 !== 1'b1) begin n_fail++; $display("FAIL blt_out_valid got %0b exp 1", out_valid_1); end
    n_checks++; if (taken_1 !== 1'b1 || mispredict_1 !== 1'b1 || illegal_1 !== 1'b0) begin n_fail++; $display("FAIL blt_flags got t%0b m%0b i%0b exp t1 m1 i0", taken_1, mispredict_1, illegal_1); end
    n_checks++; if (redirect_1 !== 32'h1000) begin n_fail++; $display("FAIL blt_redirect got %08h exp 00001000", redirect_1); end
    n_checks++; if (in_ready_1 !== 1'b0) begin n_fail++; $display("FAIL blt_in_ready_full got %0b exp 0", in_ready_1); end
    // Scramble the inputs while stalled: output must hold.
    a = 32'h0; op = 3'b000; pc = 32'h5550;
    step();
    n_checks++; if (out_valid_1 !== 1'b1 || redirect_1 !== 32'h1000 || taken_1 !== 1'b1) begin n_fail++; $display("FAIL blt_hold got v%0b %08h t%0b exp v1 00001000 t1", out_valid_1, redirect_1, taken_1); end
    n_checks++; if (mcnt_1 !== 32'd0) begin n_fail++; $display("FAIL blt_cnt_before_hs got %0d exp 0", mcnt_1); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready_1 !== 1'b1) begin n_fail++; $display("FAIL blt_in_ready_comb got %0b exp 1", in_ready_1); end
    step();
    n_checks++; if (out_valid_1 !== 1'b0) begin n_fail++; $display("FAIL blt_drained got %0b exp 0", out_valid_1); end
    n_checks++; if (bcnt_1 !== 32'd1 || mcnt_1 !== 32'd1) begin n_fail++; $display("FAIL blt_counters got %0d/%0d exp 1/1", bcnt_1, mcnt_1); end
  endtask

  task automatic test_bltu();
    op = 3'b110; a = 32'hFFFF_FFFF; b = 32'h1; pc = 32'h100; target = 32'h1000;
    pred_taken = 1'b0; out_ready = 1'b1; in_valid_1 = 1'b1;
    step();
    in_valid_1 = 1'b0;
    n_checks++; if (out_valid_1 !== 1'b1 || taken_1 !== 1'b0 || mispredict_1 !== 1'b0) begin n_fail++; $display("FAIL bltu_flags got v%0b t%0b m%0b exp v1 t0 m0", out_valid_1, taken_1, mispredict_1); end
    n_checks++; if (redirect_1 !== 32'h104) begin n_fail++; $display("FAIL bltu_redirect got %08h exp 00000104", redirect_1); end
    step();
    n_checks++; if (bcnt_1 !== 32'd2 || mcnt_1 !== 32'd1) begin n_fail++; $display("FAIL bltu_counters got %0d/%0d exp 2/1", bcnt_1, mcnt_1); end
  endtask

  task automatic test_illegal();
    op = 3'b010; a = 32'h7; b = 32'h7; pc = 32'h300; target = 32'h2000;
    pred_taken = 1'b1; out_ready = 1'b1; in_valid_1 = 1'b1;
    step();
    op = 3'b011;
    n_checks++; if (illegal_1 !== 1'b1 || taken_1 !== 1'b0 || mispredict_1 !== 1'b0) begin n_fail++; $display("FAIL illegal_010_flags got i%0b t%0b m%0b exp i1 t0 m0", illegal_1, taken_1, mispredict_1); end
    n_checks++; if (redirect_1 !== 32'h304) begin n_fail++; $display("FAIL illegal_010_redirect got %08h exp 00000304", redirect_1); end
    step();
    in_valid_1 = 1'b0;
    n_checks++; if (illegal_1 !== 1'b1 || taken_1 !== 1'b0 || mispredict_1 !== 1'b0) begin n_fail++; $display("FAIL illegal_011_flags got i%0b t%0b m%0b exp i1 t0 m0", illegal_1, taken_1, mispredict_1); end
    step();
    n_checks++; if (bcnt_1 !== 32'd2 || mcnt_1 !== 32'd1) begin n_fail++; $display("FAIL illegal_counters got %0d/%0d exp 2/1", bcnt_1, mcnt_1); end
  endtask

  task automatic test_compare_table();
    logic [2:0]   v_op [9];
    logic [W-1:0] v_a  [9];
    logic [W-1:0] v_b  [9];
    logic         v_t  [9];
    logic [W-1:0] v_pc, exp_pc;
    v_op = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111, 3'b111};
    v_a  = '{32'h5, 32'h5, 32'h5, 32'h1, 32'h8000_0000, 32'h7, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000};
    v_b  = '{32'h5, 32'h6, 32'h6, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v_t  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pred_taken = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      // Vector 3 sits at pc 0xFFFFFFFC and is not taken: pc+4 wraps to 0.
      v_pc   = 32'hFFFF_FFF0 + 32'(i * 4);
      exp_pc = v_t[i] ? (32'h4000 + 32'(i)) : (v_pc + 32'h4);
      op = v_op[i]; a = v_a[i]; b = v_b[i]; pc = v_pc; target = 32'h4000 + 32'(i);
      in_valid_1 = 1'b1;
      step();
      n_checks++; if (out_valid_1 !== 1'b1 || taken_1 !== v_t[i] || mispredict_1 !== v_t[i]) begin n_fail++; $display("FAIL cmp_vec%0d_flags got v%0b t%0b m%0b exp v1 t%0b m%0b", i, out_valid_1, taken_1, mispredict_1, v_t[i], v_t[i]); end
      n_checks++; if (redirect_1 !== exp_pc) begin n_fail++; $display("FAIL cmp_vec%0d_redirect got %08h exp %08h", i, redirect_1, exp_pc); end
    end
    in_valid_1 = 1'b0;
    step();
    n_checks++; if (bcnt_1 !== 32'd11 || mcnt_1 !== 32'd6) begin n_fail++; $display("FAIL cmp_counters got %0d/%0d exp 11/6", bcnt_1, mcnt_1); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_pc;
    int  sent = 0, got = 0, first_out = -1;
    bit  saw_full = 1'b0;
    bit  hs_in, hs_out;
    op = 3'b001; a = 32'h3; b = 32'h3; pred_taken = 1'b0; target = 32'h9000;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready  = !(cyc >= 4 && cyc <= 6);
      pc         = 32'h1000 + 32'(sent * 16);
      in_valid_3 = (sent < 5);
      #1;
      hs_in  = in_valid_3 && in_ready_3;
      hs_out = out_valid_3 && out_ready;
      if (!in_ready_3) saw_full = 1'b1;
      if (out_valid_3 && first_out < 0) first_out = cyc;
      if (hs_out) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_duplicate got beat %08h exp none", redirect_3);
        end else begin
          exp_pc = exp_q.pop_front();
          n_checks++; if (redirect_3 !== exp_pc || taken_3 !== 1'b0 || mispredict_3 !== 1'b0 || illegal_3 !== 1'b0) begin n_fail++; $display("FAIL b2b_beat%0d got %08h t%0b m%0b i%0b exp %08h t0 m0 i0", got, redirect_3, taken_3, mispredict_3, illegal_3, exp_pc); end
        end
        got++;
      end
      if (hs_in) begin
        exp_q.push_back(pc + 32'h4);
        sent++;
      end
      step();
      if (got == 5) break;
    end
    in_valid_3 = 1'b0;
    out_ready  = 1'b1;
    n_checks++; if (got !== 5) begin n_fail++; $display("FAIL b2b_count got %0d exp 5", got); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover got %0d exp 0", exp_q.size()); end
    n_checks++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_deassert got %0b exp 1", saw_full); end
    n_checks++; if (first_out !== 3) begin n_fail++; $display("FAIL b2b_latency got %0d exp 3", first_out); end
    n_checks++; if (out_valid_3 !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %0b exp 0", out_valid_3); end
    n_checks++; if (bcnt_3 !== 32'd5 || mcnt_3 !== 32'd0) begin n_fail++; $display("FAIL b2b_counters got %0d/%0d exp 5/0", bcnt_3, mcnt_3); end
  endtask

  task automatic test_flush();
    // Taken beats predicted not-taken: any leak would bump mispred_cnt.
    op = 3'b000; a = 32'h9; b = 32'h9; pred_taken = 1'b0; target = 32'h7000;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h2000 + 32'(i * 16);
      in_valid_3 = 1'b1;
      step();
    end
    pc = 32'h2100; in_valid_3 = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready_3 !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %0b exp 1", in_ready_3); end
    n_checks++; if (out_valid_3 !== 1'b1) begin n_fail++; $display("FAIL flush_prefill got %0b exp 1", out_valid_3); end
    step();
    flush = 1'b0; in_valid_3 = 1'b0;
    n_checks++; if (out_valid_3 !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0b exp 0", out_valid_3); end
    n_checks++; if (bcnt_3 !== 32'd5 || mcnt_3 !== 32'd0) begin n_fail++; $display("FAIL flush_counters got %0d/%0d exp 5/0", bcnt_3, mcnt_3); end
    step(); step(); step();
    n_checks++; if (out_valid_3 !== 1'b0 || bcnt_3 !== 32'd5 || mcnt_3 !== 32'd0) begin n_fail++; $display("FAIL flush_settled got v%0b %0d/%0d exp v0 5/0", out_valid_3, bcnt_3, mcnt_3); end
  endtask

  task automatic test_reset_mid();
    op = 3'b000; a = 32'h1; b = 32'h1; pred_taken = 1'b0; out_ready = 1'b0;
    in_valid_3 = 1'b1; pc = 32'h3000;
    step(); step();
    in_valid_3 = 1'b0; rst = 1'b1;
    step();
    n_checks++; if (out_valid_3 !== 1'b0 || in_ready_3 !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got v%0b r%0b exp v0 r0", out_valid_3, in_ready_3); end
    rst = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    n_checks++; if (out_valid_3 !== 1'b0 || bcnt_3 !== 32'd0 || mcnt_3 !== 32'd0) begin n_fail++; $display("FAIL rstmid_dropped got v%0b %0d/%0d exp v0 0/0", out_valid_3, bcnt_3, mcnt_3); end
  endtask

  task automatic test_saturation();
    op = 3'b000; a = 32'h9; b = 32'h9; pred_taken = 1'b0; target = 32'h50; pc = 32'h400;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid_4 = 1'b1;
      step();
    end
    in_valid_4 = 1'b0;
    step();
    n_checks++; if (bcnt_4 !== 4'hF || mcnt_4 !== 4'hF) begin n_fail++; $display("FAIL sat_counters got %0h/%0h exp F/F", bcnt_4, mcnt_4); end
    out_ready = 1'b0; in_valid_4 = 1'b1;
    step();
    in_valid_4 = 1'b0;
    n_checks++; if (out_valid_4 !== 1'b1 || taken_4 !== 1'b1 || mispredict_4 !== 1'b1 || illegal_4 !== 1'b0 || redirect_4 !== 32'h50) begin n_fail++; $display("FAIL sat_pending got v%0b t%0b m%0b i%0b %08h exp v1 t1 m1 i0 00000050", out_valid_4, taken_4, mispredict_4, illegal_4, redirect_4); end
    cnt_clr = 1'b1; out_ready = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_checks++; if (bcnt_4 !== 4'h0 || mcnt_4 !== 4'h0) begin n_fail++; $display("FAIL clr_priority got %0h/%0h exp 0/0", bcnt_4, mcnt_4); end
    in_valid_4 = 1'b1;
    step();
    in_valid_4 = 1'b0;
    step();
    n_checks++; if (bcnt_4 !== 4'h1 || mcnt_4 !== 4'h1) begin n_fail++; $display("FAIL clr_then_count got %0h/%0h exp 1/1", bcnt_4, mcnt_4); end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0; pred_taken = 1'b0;
    op = 3'b000; a = '0; b = '0; pc = '0; target = '0;
    in_valid_1 = 1'b0; in_valid_3 = 1'b0; in_valid_4 = 1'b0;
    test_reset();
    test_blt();
    test_bltu();
    test_illegal();
    test_compare_table();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
